// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: fetch FSM states, the bubble encoding and the IF/ID record.
package cpu_pkg;

   localparam int unsigned CPU_XLEN = 32;

   localparam logic [CPU_XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      BUF,
      DROP
   } fetch_state_e;

   typedef struct packed {
      logic [CPU_XLEN-1:0] pc;
      logic [CPU_XLEN-1:0] instr;
      logic                valid;
   } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush clears to a bubble, hold freezes, otherwise load an
// instruction or a bubble that keeps the previous pc.
module if_id_reg
   import cpu_pkg::*;
#(
   parameter logic [CPU_XLEN-1:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   input  logic                hold,
   input  logic                load,
   input  logic [CPU_XLEN-1:0] load_pc,
   input  logic [CPU_XLEN-1:0] load_instr,
   output logic [CPU_XLEN-1:0] pc,
   output logic [CPU_XLEN-1:0] instr,
   output logic                valid
);

   if_id_t r;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r <= '{pc: '0, instr: NOP_INSTR, valid: 1'b0};
      end else if (!hold) begin
         if (load) begin
            r <= '{pc: load_pc, instr: load_instr, valid: 1'b1};
         end else begin
            r.instr <= NOP_INSTR;
            r.valid <= 1'b0;
         end
      end
   end

   assign pc    = r.pc;
   assign instr = r.instr;
   assign valid = r.valid;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, single-outstanding instruction-memory handshake with a
// one-entry response buffer, feeding the IF/ID register.
module fetch_stage
   import cpu_pkg::*;
#(
   parameter int unsigned      XLEN      = 32,
   parameter logic [XLEN-1:0]  RESET_PC  = 32'h0000_0000,
   parameter logic [XLEN-1:0]  NOP_INSTR = cpu_pkg::NOP_INSTR
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            pc_write,
   input  logic            instr_flush,
   input  logic            IF_ID_reg_write,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            im_req,
   output logic [XLEN-1:0] im_addr,
   input  logic            im_rvalid,
   input  logic [XLEN-1:0] im_rdata,
   output logic [XLEN-1:0] if_id_pc,
   output logic [XLEN-1:0] if_id_instr,
   output logic            if_id_valid
);

   fetch_state_e    state, state_n;
   logic [XLEN-1:0] pc, pc_n;
   logic [XLEN-1:0] buffer, buffer_n;
   logic [XLEN-1:0] redirect_aligned;
   logic [XLEN-1:0] deliver_instr;
   logic            adv;
   logic            deliver;

   assign adv              = pc_write & ~IF_ID_reg_write & ~instr_flush;
   assign redirect_aligned = redirect_pc & ~XLEN'(3);
   assign im_addr          = pc;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         pc     <= RESET_PC;
         buffer <= '0;
      end else begin
         state  <= state_n;
         pc     <= pc_n;
         buffer <= buffer_n;
      end
   end

   always_comb begin
      state_n       = state;
      pc_n          = pc;
      buffer_n      = buffer;
      im_req        = 1'b0;
      deliver       = 1'b0;
      deliver_instr = buffer;

      unique case (state)
         IDLE: begin
            if (instr_flush) begin
               pc_n = redirect_aligned;
            end else if (pc_write) begin
               im_req  = 1'b1;
               state_n = WAIT;
            end
         end
         WAIT: begin
            if (instr_flush) begin
               pc_n    = redirect_aligned;
               state_n = im_rvalid ? IDLE : DROP;
            end else if (im_rvalid) begin
               if (adv) begin
                  deliver       = 1'b1;
                  deliver_instr = im_rdata;
                  state_n       = IDLE;
               end else begin
                  buffer_n = im_rdata;
                  state_n  = BUF;
               end
            end
         end
         BUF: begin
            if (instr_flush) begin
               buffer_n = '0;
               pc_n     = redirect_aligned;
               state_n  = IDLE;
            end else if (adv) begin
               deliver = 1'b1;
               state_n = IDLE;
            end
         end
         DROP: begin
            // A flush here retargets pc; the stale response still has to drain.
            if (instr_flush) begin
               pc_n = redirect_aligned;
            end
            if (im_rvalid) begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase

      if (deliver) begin
         pc_n = pc + XLEN'(4);
      end
   end

   if_id_reg #(
      .NOP_INSTR(NOP_INSTR)
   ) u_if_id_reg (
      .clk        (clk),
      .rst        (rst),
      .flush      (instr_flush),
      .hold       (IF_ID_reg_write),
      .load       (deliver),
      .load_pc    (pc),
      .load_instr (deliver_instr),
      .pc         (if_id_pc),
      .instr      (if_id_instr),
      .valid      (if_id_valid)
   );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized control,
// all cycles compared against a flag-based behavioural model of the fetch front end.
module tb_fetch_stage;

   localparam logic [31:0] NOP    = 32'h0000_0013;
   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst, pc_write, instr_flush, IF_ID_reg_write, im_rvalid;
   logic [31:0] redirect_pc, im_rdata;
   logic        im_req, if_id_valid;
   logic [31:0] im_addr, if_id_pc, if_id_instr;

   always #5 clk = ~clk;

   fetch_stage #(
      .XLEN      (32),
      .RESET_PC  (RST_PC),
      .NOP_INSTR (NOP)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .pc_write        (pc_write),
      .instr_flush     (instr_flush),
      .IF_ID_reg_write (IF_ID_reg_write),
      .redirect_pc     (redirect_pc),
      .im_req          (im_req),
      .im_addr         (im_addr),
      .im_rvalid       (im_rvalid),
      .im_rdata        (im_rdata),
      .if_id_pc        (if_id_pc),
      .if_id_instr     (if_id_instr),
      .if_id_valid     (if_id_valid)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // reference model: pc, an outstanding-fetch flag, a "response is stale" flag, a buffer
   bit          known = 1'b0;
   logic [31:0] m_pc;
   bit          m_inflight, m_killed, m_bufv;
   logic [31:0] m_buf;
   logic [31:0] m_ifpc, m_ifinstr;
   bit          m_ifvalid;

   // memory: one response outstanding, latency chosen at request time
   int          lat     = 1;
   int          mem_cnt = 0;
   logic [31:0] mem_addr;

   bit          last_req;
   logic [31:0] last_addr;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [31:0] h;
      if (a == 32'h0) return 32'h00A0_0093;
      h = a * 32'h9E37_79B1;
      return h ^ 32'h0000_0013;
   endfunction

   task automatic step(input bit r, input bit pw, input bit fl, input bit hd, input logic [31:0] rd);
      bit          exp_req, rv, dlv, adv;
      logic [31:0] rdat, d_instr;
      @(negedge clk);
      rst             = r;
      pc_write        = pw;
      instr_flush     = fl;
      IF_ID_reg_write = hd;
      redirect_pc     = rd;
      rv   = 1'b0;
      rdat = $urandom;
      if (mem_cnt > 0) begin
         mem_cnt--;
         if (mem_cnt == 0) begin
            rv   = 1'b1;
            rdat = mem_word(mem_addr);
         end
      end
      im_rvalid = rv;
      im_rdata  = rdat;
      #1;
      last_req  = im_req;
      last_addr = im_addr;
      if (known) begin
         exp_req = !m_inflight && !m_bufv && !fl && pw;
         check_eq("im_req", {31'b0, im_req}, {31'b0, exp_req});
         if (exp_req) check_eq("im_addr", im_addr, m_pc);
         check_eq("if_id_pc", if_id_pc, m_ifpc);
         check_eq("if_id_instr", if_id_instr, m_ifinstr);
         check_eq("if_id_valid", {31'b0, if_id_valid}, {31'b0, m_ifvalid});
      end
      @(posedge clk);
      if (r) begin
         known      = 1'b1;
         m_pc       = RST_PC;
         m_inflight = 1'b0;
         m_killed   = 1'b0;
         m_bufv     = 1'b0;
         m_ifpc     = 32'h0;
         m_ifinstr  = NOP;
         m_ifvalid  = 1'b0;
      end else if (known) begin
         adv     = pw && !hd && !fl;
         dlv     = 1'b0;
         d_instr = NOP;
         if (fl) begin
            m_pc   = {rd[31:2], 2'b00};
            m_bufv = 1'b0;
            if (m_inflight) begin
               if (rv) begin
                  m_inflight = 1'b0;
                  m_killed   = 1'b0;
               end else begin
                  m_killed = 1'b1;
               end
            end
         end else if (m_inflight) begin
            if (rv) begin
               m_inflight = 1'b0;
               if (m_killed) m_killed = 1'b0;
               else if (adv) begin
                  dlv     = 1'b1;
                  d_instr = rdat;
               end else begin
                  m_bufv = 1'b1;
                  m_buf  = rdat;
               end
            end
         end else if (m_bufv) begin
            if (adv) begin
               dlv     = 1'b1;
               d_instr = m_buf;
               m_bufv  = 1'b0;
            end
         end else if (pw) begin
            m_inflight = 1'b1;
         end
         if (fl) begin
            m_ifpc    = 32'h0;
            m_ifinstr = NOP;
            m_ifvalid = 1'b0;
         end else if (!hd) begin
            if (dlv) begin
               m_ifpc    = m_pc;
               m_ifinstr = d_instr;
               m_ifvalid = 1'b1;
            end else begin
               m_ifinstr = NOP;
               m_ifvalid = 1'b0;
            end
         end
         if (dlv) m_pc = m_pc + 32'd4;
      end
      if (last_req) begin
         mem_cnt  = lat;
         mem_addr = last_addr;
      end
   endtask

   // quiet cycles after reset let any abandoned response drain while IDLE
   task automatic do_reset();
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic run_until_req(input string tag, input logic [31:0] exp_addr);
      bit found = 1'b0;
      for (int i = 0; i < 12 && !found; i++) begin
         step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
         found = last_req;
      end
      check_eq({tag, "_seen"}, {31'b0, found}, 32'h1);
      check_eq({tag, "_addr"}, last_addr, exp_addr);
   endtask

   initial begin
      bit found;
      rst = 1'b1; pc_write = 1'b0; instr_flush = 1'b0; IF_ID_reg_write = 1'b0;
      redirect_pc = '0; im_rvalid = 1'b0; im_rdata = '0;

      do_reset();
      #2;
      check_eq("rst_pc", if_id_pc, 32'h0);
      check_eq("rst_instr", if_id_instr, NOP);
      check_eq("rst_valid", {31'b0, if_id_valid}, 32'h0);

      // free run, 1-cycle memory
      lat = 1;
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      check_eq("first_req", {31'b0, last_req}, 32'h1);
      check_eq("first_addr", last_addr, 32'h0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      #2;
      check_eq("first_ifpc", if_id_pc, 32'h0);
      check_eq("first_instr", if_id_instr, 32'h00A0_0093);
      check_eq("first_valid", {31'b0, if_id_valid}, 32'h1);
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      check_eq("second_addr", last_addr, 32'h4);

      // load-use stall while the response for 8 returns
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
         found = last_req && (last_addr == 32'h8);
      end
      check_eq("find_a8", {31'b0, found}, 32'h1);
      step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      #2;
      check_eq("buf_ifpc", if_id_pc, 32'h8);
      check_eq("buf_instr", if_id_instr, mem_word(32'h8));
      check_eq("buf_valid", {31'b0, if_id_valid}, 32'h1);

      // flush with a 3-cycle fetch in flight
      lat = 3;
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      check_eq("after_buf_addr", last_addr, 32'hC);
      step(1'b0, 1'b1, 1'b1, 1'b0, 32'h100);
      #2;
      check_eq("flush_valid", {31'b0, if_id_valid}, 32'h0);
      check_eq("flush_instr", if_id_instr, NOP);
      lat = 1;
      run_until_req("drop", 32'h100);

      // flush coincident with the response, misaligned target
      step(1'b0, 1'b1, 1'b1, 1'b0, 32'h103);
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      check_eq("same_cycle_req", {31'b0, last_req}, 32'h1);
      check_eq("misalign_addr", last_addr, 32'h100);

      // flush beats hold, then a second flush during DROP
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      lat = 3;
      step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
      step(1'b0, 1'b1, 1'b1, 1'b1, 32'h180);
      #2;
      check_eq("flush_hold_valid", {31'b0, if_id_valid}, 32'h0);
      check_eq("flush_hold_instr", if_id_instr, NOP);
      step(1'b0, 1'b1, 1'b1, 1'b0, 32'h200);
      lat = 2;
      run_until_req("drop2", 32'h200);

      // reset while WAIT; stray response lands in IDLE
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      #2;
      check_eq("rstw_valid", {31'b0, if_id_valid}, 32'h0);
      check_eq("rstw_instr", if_id_instr, NOP);
      check_eq("rstw_pc", if_id_pc, 32'h0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      lat = 1;
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      check_eq("restart_addr", last_addr, RST_PC);

      // pc wrap
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC);
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      check_eq("wrap_req_addr", last_addr, 32'hFFFF_FFFC);
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      #2;
      check_eq("wrap_ifpc", if_id_pc, 32'hFFFF_FFFC);
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      check_eq("wrap_next_addr", last_addr, 32'h0);

      // randomized control
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            do_reset();
         end else begin
            lat = $urandom_range(1, 3);
            step(1'b0, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 3) == 0, $urandom);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
